msg_printer: RTL and testbench
==============================

# msg_printer

Parametrised successor of the UART string printer. On a start request it fetches a stored message by ID from a ROM and streams its bytes, in order, to the UART transmitter over a valid/ready handshake. It adds a one-deep request buffer, an abort input and an optional CR/LF trailer. It sits between command-decode logic and the UART TX block.

## Interface
Parameters:
- N_STR, 4: number of stored messages; ID_W = $clog2(N_STR), minimum 1.
- MAX_LEN, 32: maximum message length in bytes; LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to print message str_id; sampled every cycle.
- str_id  in  ID_W  message ID, sampled together with start.
- abort  in  1  terminates the current message after any in-flight handshake and clears the pending request.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  UART TX can accept a byte; transfer occurs when tx_valid && tx_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a message completes or is aborted.
- overflow  out  1  one-cycle pulse when a start is dropped.
- printer_state  out  2  current FSM state (debug).

## Operation
- FSM encoding: IDLE=0, LOAD=1, SEND=2, FINISH=3.
- IDLE: on start, capture str_id into cur_id and go to LOAD.
- LOAD: latch len = rom length(cur_id) and set idx=0.
  - If len==0, go to FINISH; with the trailer enabled, go to SEND for the trailer bytes only.
  - Otherwise go to SEND.
- SEND: tx_valid=1 and tx_data = rom byte[idx] of cur_id. Byte 0 is the first byte sent, taken from bits [7:0].
  - On each handshake, idx increments.
  - A handshake on idx==len-1, with no trailer, goes to FINISH.
- FINISH: done=1 for one cycle, tx_valid=0.
  - If a request is pending, load pend_id into cur_id, clear pending and go to LOAD.
  - Otherwise go to IDLE.
- Pending buffer: a start while busy is stored in pend_id if the buffer is empty.
  - If the buffer is full, the start is dropped and overflow pulses.
  - A start in the same cycle as FINISH goes into the buffer if it is empty. The existing pending request wins the next LOAD.
- abort in SEND:
  - If a handshake is in the same cycle, that byte counts as sent.
  - The next state is FINISH; pending is cleared.
  - abort in IDLE/LOAD/FINISH only clears pending. A LOAD still proceeds.
- abort and start in the same cycle: abort is applied first, then start is buffered.
- idx is LEN_W bits wide; compare against len-1 only when len≠0. idx never wraps.
- str_id ≥ N_STR: the ROM returns len=0.

## Timing
- Reset values: tx_data=0, tx_valid=0, busy=0, done=0, overflow=0, printer_state=IDLE; pending empty.
- Latency: start at cycle 0 → LOAD at cycle 1 → tx_valid high with byte 0 at cycle 2.
- With tx_ready held high, bytes go out back-to-back, one per cycle, with no bubbles.
- With tx_ready held high and no trailer, done pulses at cycle 2+len.
- A pending request starts its LOAD in the cycle after FINISH.
- tx_data and tx_valid come from registers or from idx/cur_id registers only. They have no combinational path from tx_ready.
- tx_valid never drops without a handshake, except on abort or reset.
- Reset mid-message: all outputs return to their reset values immediately. The partial message is not resumed.

## Configuration
- PRINTER_CRLF_EN defined: after the last message byte, SEND also emits 0x0D then 0x0A, and FINISH follows the 0x0A handshake.
  - A zero-length message emits CR/LF only.
  - abort also skips any unsent trailer bytes.
- PRINTER_CRLF_EN undefined: no trailer; a zero-length message goes LOAD→FINISH without any tx_valid.

## Structure
- Shared package printer_pkg holds:
  - the state encoding constants;
  - the CR/LF byte constants;
  - message ID constants.
- Sub-module msg_rom (parameters N_STR, MAX_LEN): combinational `id → {byte[idx], len}` lookup.
  - Stored strings are packed with byte 0 in the LSB.
  - Out-of-range IDs return len=0.

## Test plan
- Message 1 = "OK" (len 2), tx_ready=1: start at cycle 0 → 0x4F at cycle 2, 0x4B at cycle 3, done at cycle 4. With PRINTER_CRLF_EN: 0x0D, 0x0A, then done at cycle 6.
- tx_ready toggling 1/0 every cycle on a 5-byte message: each byte is sent exactly once and in order; tx_data is stable while tx_valid && !tx_ready.
- Three starts (IDs 0, 1, 2) on consecutive cycles: ID 0 is printed, then ID 1 after done; ID 2 pulses overflow and is never printed.
- abort asserted on the handshake of byte 2 of a 10-byte message: bytes 0–2 are sent, done pulses next cycle, busy=0 after that, and the pending request is discarded.
- str_id=N_STR, or a zero-length message: done at cycle 2 with no tx_valid; with PRINTER_CRLF_EN, only 0x0D and 0x0A are sent.
- rst_n low mid-message with tx_valid=1: tx_valid, busy and done go to 0 asynchronously; a new start after release prints from byte 0.

Source files
------------

// File: rtl/printer_pkg.sv
// Shared types and constants for the message printer: FSM encoding, trailer bytes
// and the stored message table (strings packed with byte 0 in the LSB).
package printer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SEND   = 2'd2,
    ST_FINISH = 2'd3
  } printer_state_e;

  localparam logic [7:0] CR_BYTE = 8'h0D;
  localparam logic [7:0] LF_BYTE = 8'h0A;

  localparam int unsigned MSG_HELLO  = 0;
  localparam int unsigned MSG_OK     = 1;
  localparam int unsigned MSG_DIGITS = 2;
  localparam int unsigned MSG_EMPTY  = 3;

  localparam int unsigned ROM_BYTES  = 16;
  localparam int unsigned ROM_TEXT_W = ROM_BYTES * 8;

  // Literals are written reversed so the first character lands in bits [7:0].
  function automatic logic [ROM_TEXT_W-1:0] rom_text(input int unsigned id);
    case (id)
      MSG_HELLO:  rom_text = ROM_TEXT_W'("OLLEH");
      MSG_OK:     rom_text = ROM_TEXT_W'("KO");
      MSG_DIGITS: rom_text = ROM_TEXT_W'("9876543210");
      default:    rom_text = '0;
    endcase
  endfunction

  function automatic int unsigned rom_len(input int unsigned id);
    case (id)
      MSG_HELLO:  rom_len = 5;
      MSG_OK:     rom_len = 2;
      MSG_DIGITS: rom_len = 10;
      MSG_EMPTY:  rom_len = 0;
      default:    rom_len = 0;
    endcase
  endfunction

endpackage

// File: rtl/msg_printer_rom.sv
// Combinational message lookup: id/idx -> byte at idx and message length.
// IDs at or above N_STR read as empty messages.
module msg_rom
  import printer_pkg::*;
#(
  parameter int unsigned N_STR   = 4,
  parameter int unsigned MAX_LEN = 32,
  localparam int unsigned ID_W   = (N_STR > 1) ? $clog2(N_STR) : 1,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic [ID_W-1:0]  id,
  input  logic [LEN_W-1:0] idx,
  output logic [7:0]       data_c,
  output logic [LEN_W-1:0] len_c
);

  logic [ROM_TEXT_W-1:0] text;
  int unsigned           len_raw;

  always_comb begin
    text    = '0;
    len_raw = 0;
    data_c  = '0;
    if (32'(id) < N_STR) begin
      text    = rom_text(32'(id));
      len_raw = rom_len(32'(id));
    end
    if (len_raw > MAX_LEN) len_raw = MAX_LEN;
    len_c = LEN_W'(len_raw);
    for (int unsigned b = 0; b < ROM_BYTES; b++) begin
      if (32'(idx) == b && b < len_raw) data_c = text[b*8 +: 8];
    end
  end

endmodule

// File: rtl/msg_printer.sv
// Streams a stored message over a valid/ready byte interface, with a one-deep
// request buffer and abort. Define PRINTER_CRLF_EN to append a CR/LF trailer.
module msg_printer
  import printer_pkg::*;
#(
  parameter int unsigned N_STR   = 4,
  parameter int unsigned MAX_LEN = 32,
  localparam int unsigned ID_W   = (N_STR > 1) ? $clog2(N_STR) : 1,
  localparam int unsigned LEN_W  = $clog2(MAX_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [ID_W-1:0] str_id,
  input  logic            abort,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            busy,
  output logic            done,
  output logic            overflow,
  output logic [1:0]      printer_state
);

`ifdef PRINTER_CRLF_EN
  localparam int unsigned TRL_N = 2;
  localparam int unsigned IDX_W = LEN_W + 1;
`else
  localparam int unsigned TRL_N = 0;
  localparam int unsigned IDX_W = LEN_W;
`endif

  printer_state_e   state_q, state_d;
  logic [ID_W-1:0]  cur_id_q, cur_id_d, pend_id_q, pend_id_d;
  logic             pend_vld_q, pend_vld_d;
  logic [LEN_W-1:0] len_q, len_d, rom_len_c, rom_idx_c;
  logic [IDX_W-1:0] idx_q, idx_d, pos_c, last_c;
  logic [7:0]       rom_data_c, byte_c, tx_data_d;
  logic             tx_valid_d, done_d, overflow_d, hs_c;

  msg_rom #(.N_STR(N_STR), .MAX_LEN(MAX_LEN)) u_rom (
    .id     (cur_id_q),
    .idx    (rom_idx_c),
    .data_c (rom_data_c),
    .len_c  (rom_len_c)
  );

  // Byte for the next position to present: 0 when loading, idx+1 after a handshake.
  always_comb begin
    pos_c     = (state_q == ST_LOAD) ? '0 : idx_q + IDX_W'(1);
    last_c    = IDX_W'(len_q) + IDX_W'(TRL_N) - IDX_W'(1);
    rom_idx_c = LEN_W'(pos_c);
    byte_c    = rom_data_c;
`ifdef PRINTER_CRLF_EN
    begin
      logic [LEN_W-1:0] len_sel;
      len_sel = (state_q == ST_LOAD) ? rom_len_c : len_q;
      if (pos_c == IDX_W'(len_sel))     byte_c = CR_BYTE;
      else if (pos_c > IDX_W'(len_sel)) byte_c = LF_BYTE;
    end
`endif
  end

  always_comb begin
    state_d    = state_q;
    cur_id_d   = cur_id_q;
    pend_id_d  = pend_id_q;
    pend_vld_d = pend_vld_q && !abort;
    len_d      = len_q;
    idx_d      = idx_q;
    tx_data_d  = tx_data;
    tx_valid_d = 1'b0;
    done_d     = 1'b0;
    overflow_d = 1'b0;
    hs_c       = tx_valid && tx_ready;

    // Abort clears the buffer first, then a start while busy takes the free slot.
    if (start && state_q != ST_IDLE) begin
      if (pend_vld_d) begin
        overflow_d = 1'b1;
      end else if (state_q != ST_FINISH) begin
        pend_vld_d = 1'b1;
        pend_id_d  = str_id;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_id_d = str_id;
          state_d  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        len_d = rom_len_c;
        idx_d = '0;
        if (32'(rom_len_c) + TRL_N == 0) begin
          state_d = ST_FINISH;
          done_d  = 1'b1;
        end else begin
          state_d    = ST_SEND;
          tx_valid_d = 1'b1;
          tx_data_d  = byte_c;
        end
      end
      ST_SEND: begin
        tx_valid_d = 1'b1;
        if (hs_c) begin
          idx_d = pos_c;
          if (idx_q == last_c) begin
            state_d    = ST_FINISH;
            tx_valid_d = 1'b0;
            done_d     = 1'b1;
          end else begin
            tx_data_d = byte_c;
          end
        end
        if (abort) begin
          state_d    = ST_FINISH;
          tx_valid_d = 1'b0;
          done_d     = 1'b1;
        end
      end
      ST_FINISH: begin
        // An empty buffer lets a same-cycle start go straight to LOAD.
        pend_vld_d = 1'b0;
        if (pend_vld_q && !abort) begin
          cur_id_d = pend_id_q;
          state_d  = ST_LOAD;
        end else if (start) begin
          cur_id_d = str_id;
          state_d  = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cur_id_q   <= '0;
      pend_id_q  <= '0;
      pend_vld_q <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      pend_id_q  <= pend_id_d;
      pend_vld_q <= pend_vld_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tx_data    <= tx_data_d;
      tx_valid   <= tx_valid_d;
      busy       <= (state_d != ST_IDLE);
      done       <= done_d;
      overflow   <= overflow_d;
    end
  end

  assign printer_state = state_q;

endmodule

// File: tb/tb_msg_printer.sv
// Self-checking bench for msg_printer: directed timing checks plus random
// back-pressure, compared against a string-table model of the message set.
module tb_msg_printer;

  localparam int N_STR_TB = 3;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [1:0] str_id;
  logic       abort;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       overflow;
  logic [1:0] printer_state;

  msg_printer #(.N_STR(N_STR_TB), .MAX_LEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .str_id        (str_id),
    .abort         (abort),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .printer_state (printer_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_assert = 0;
  int         n_fail   = 0;
  string      msgs [4];
  logic [7:0] exp_q [$];
  logic [7:0] got   [$];
  logic       stall_q = 1'b0;
  logic [7:0] stall_data = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Model: bytes a complete print of message id puts on the wire.
  task automatic push_msg(input int id);
    if (id < N_STR_TB)
      for (int i = 0; i < msgs[id].len(); i++) exp_q.push_back(8'(msgs[id][i]));
`ifdef PRINTER_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endtask

  task automatic cmp_queue(input string tag);
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk({tag, "_byte"}, 32'(got[i]), 32'(exp_q[i]));
  endtask

  // Start a message with tx_ready high and check every cycle of its timeline.
  task automatic run_timed(input int id, input string tag);
    exp_q.delete();
    got.delete();
    push_msg(id);
    tx_ready = 1'b1;
    start    = 1'b1;
    str_id   = 2'(id);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_load_state"}, 32'(printer_state), 32'd1);
    chk({tag, "_load_busy"}, 32'(busy), 32'd1);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge clk);
      chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_data"}, 32'(tx_data), 32'(exp_q[k]));
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_fin_valid"}, 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    cmp_queue(tag);
  endtask

  // Handshake recorder and hold-stability check while stalled.
  always @(posedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(stall_data));
      end
      if (tx_valid && tx_ready) got.push_back(tx_data);
      stall_q    = tx_valid && !tx_ready && !abort;
      stall_data = tx_data;
    end
  end

  initial begin
    int id;
    int seen;
    int n_done;

    msgs[0] = "HELLO";
    msgs[1] = "OK";
    msgs[2] = "0123456789";
    msgs[3] = "";
    rst_n    = 1'b0;
    start    = 1'b0;
    str_id   = 2'd0;
    abort    = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_data", 32'(tx_data), 32'd0);
    chk("rst_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_state", 32'(printer_state), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_timed(1, "ok");
    run_timed(3, "oor");
    run_timed(0, "hello");

    // Alternating back-pressure on the 5-byte message.
    exp_q.delete();
    got.delete();
    push_msg(0);
    tx_ready = 1'b1;
    start    = 1'b1;
    str_id   = 2'd0;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      tx_ready = ~tx_ready;
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("toggle_done", 32'(seen), 32'd1);
    cmp_queue("toggle");
    tx_ready = 1'b1;
    @(negedge clk);

    // Random IDs under random back-pressure.
    for (int t = 0; t < 8; t++) begin
      id = int'($urandom_range(0, 3));
      exp_q.delete();
      got.delete();
      push_msg(id);
      start  = 1'b1;
      str_id = 2'(id);
      @(negedge clk);
      start = 1'b0;
      seen  = 0;
      for (int c = 0; c < 400 && seen == 0; c++) begin
        tx_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (done) seen = 1;
      end
      chk("rand_done", 32'(seen), 32'd1);
      cmp_queue("rand");
      tx_ready = 1'b1;
      @(negedge clk);
      chk("rand_idle", 32'(busy), 32'd0);
    end

    // Three back-to-back starts: second buffered, third dropped.
    exp_q.delete();
    got.delete();
    push_msg(0);
    push_msg(1);
    tx_ready = 1'b1;
    start    = 1'b1;
    str_id   = 2'd0;
    @(negedge clk);
    str_id = 2'd1;
    @(negedge clk);
    chk("buf_no_ovf", 32'(overflow), 32'd0);
    str_id = 2'd2;
    @(negedge clk);
    start = 1'b0;
    chk("buf_ovf", 32'(overflow), 32'd1);
    n_done = 0;
    seen   = 0;
    for (int c = 0; c < 200 && seen == 0; c++) begin
      @(negedge clk);
      if (done) n_done++;
      if (!busy) seen = 1;
    end
    chk("buf_idle", 32'(seen), 32'd1);
    chk("buf_ndone", 32'(n_done), 32'd2);
    cmp_queue("buf");

    // Abort on the handshake of byte 2 with a request pending.
    exp_q.delete();
    got.delete();
    for (int i = 0; i < 3; i++) exp_q.push_back(8'(msgs[2][i]));
    start  = 1'b1;
    str_id = 2'd2;
    @(negedge clk);
    str_id = 2'd1;
    @(negedge clk);
    start = 1'b0;
    seen  = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      if (tx_valid && tx_data == 8'(msgs[2][2])) seen = 1;
      else @(negedge clk);
    end
    chk("abort_reach", 32'(seen), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_done", 32'(done), 32'd1);
    chk("abort_valid", 32'(tx_valid), 32'd0);
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_pend", 32'(busy), 32'd0);
    cmp_queue("abort");

    // Asynchronous reset mid-message, then a clean restart.
    tx_ready = 1'b0;
    start    = 1'b1;
    str_id   = 2'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("mid_valid", 32'(tx_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(tx_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_state", 32'(printer_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_timed(0, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
